// File: rtl/cnc_stream_engine_if.sv
// CNC stream interface: driver-side sample stream in, per-frame result out.
interface cnc_stream_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 17
);
  logic              in_en;
  logic [1:0]        mode;
  logic [DATA_W-1:0] in_data;
  logic              out_en;
  logic [OUT_W-1:0]  out_data;

  // Driver side: produces samples, consumes results.
  modport master (
    output in_en, mode, in_data,
    input  out_en, out_data
  );

  // Engine side: consumes samples, produces results.
  modport slave (
    input  in_en, mode, in_data,
    output out_en, out_data
  );
endinterface

// File: rtl/cnc_stream_engine.sv
// CNC stream engine: reduces each contiguous in_en frame to one result
// (SUM / MAX / MIN / SAD), selected by the mode seen on the frame's first sample.
// Frames reaching MAX_LEN samples are force-closed.
module cnc_stream_engine #(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 17,
  parameter int MAX_LEN = 512
) (
  input logic                clk,
  input logic                reset,
  cnc_stream_engine_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam logic [1:0] MODE_SAD = 2'd3;

  logic [0:0]        state_r;
  logic [1:0]        mode_r;
  logic [OUT_W-1:0]  acc_r;
  logic [DATA_W-1:0] prev_r;
  logic [CNT_W-1:0]  count_r;
  logic              out_en_r;
  logic [OUT_W-1:0]  out_data_r;

  logic [OUT_W-1:0]  sample_s;
  logic [OUT_W-1:0]  acc_next_s;
  logic [OUT_W-1:0]  acc_first_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              close_s;

  // Unsigned absolute difference of two samples.
  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

  assign sample_s     = OUT_W'(bus.in_data);
  assign count_next_s = count_r + CNT_ONE;
  assign close_s      = (count_next_s == CNT_MAX);

  // Accumulator update for a continuing sample, per the latched mode.
  always_comb begin
    acc_next_s = acc_r;
    case (mode_r)
      MODE_SUM: acc_next_s = acc_r + sample_s;
      MODE_MAX: begin
        if (sample_s > acc_r) begin
          acc_next_s = sample_s;
        end else begin
          acc_next_s = acc_r;
        end
      end
      MODE_MIN: begin
        if (sample_s < acc_r) begin
          acc_next_s = sample_s;
        end else begin
          acc_next_s = acc_r;
        end
      end
      MODE_SAD: acc_next_s = acc_r + OUT_W'(abs_diff(bus.in_data, prev_r));
      default:  acc_next_s = acc_r;
    endcase
  end

  // Accumulator seed for a frame's first sample; SAD has no difference yet.
  always_comb begin
    acc_first_s = sample_s;
    if (bus.mode == MODE_SAD) begin
      acc_first_s = {OUT_W{1'b0}};
    end else begin
      acc_first_s = sample_s;
    end
  end

  // Frame FSM, accumulator state and registered result strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= 2'd0;
      acc_r      <= {OUT_W{1'b0}};
      prev_r     <= {DATA_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      out_en_r   <= 1'b0;
      out_data_r <= {OUT_W{1'b0}};
    end else begin
      out_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_en) begin
            mode_r  <= bus.mode;
            prev_r  <= bus.in_data;
            count_r <= CNT_ONE;
            acc_r   <= acc_first_s;
            state_r <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (bus.in_en) begin
            acc_r   <= acc_next_s;
            prev_r  <= bus.in_data;
            count_r <= count_next_s;
            if (close_s) begin
              // Frame is full: emit the result including this sample.
              out_data_r <= acc_next_s;
              out_en_r   <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end else begin
            out_data_r <= acc_r;
            out_en_r   <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_en   = out_en_r;
  assign bus.out_data = out_data_r;

endmodule

// File: tb/tb_cnc_stream_engine.sv
// Self-checking bench for cnc_stream_engine: directed frames from the test
// plan plus randomized frames, checked against a frame-level reference model.
module tb_cnc_stream_engine;

  localparam int DATA_W  = 8;
  localparam int OUT_W   = 17;
  localparam int MAX_LEN = 512;

  typedef int unsigned uq_t[$];
  typedef logic [1:0]  mq_t[$];

  logic clk = 1'b0;
  logic reset;

  cnc_stream_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

  cnc_stream_engine #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  uq_t mon_val, mon_cyc;   // observed result pulses
  uq_t exp_val, exp_cyc;   // model predictions

  // Posedge counter used to time result pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which out_en is high.
  always @(posedge clk) begin
    #1;
    if (bus.out_en === 1'b1) begin
      mon_val.push_back(int'(bus.out_data));
      mon_cyc.push_back(cyc);
    end
  end

  // Reference reduction of one complete frame.
  function automatic int unsigned ref_result(input logic [1:0] m, input uq_t s);
    int unsigned r;
    case (m)
      2'd0: begin r = 0; foreach (s[i]) r += s[i]; end
      2'd1: begin r = 0; foreach (s[i]) if (s[i] > r) r = s[i]; end
      2'd2: begin r = 255; foreach (s[i]) if (s[i] < r) r = s[i]; end
      2'd3: begin
        r = 0;
        for (int i = 1; i < s.size(); i++)
          r += (s[i] > s[i-1]) ? (s[i] - s[i-1]) : (s[i-1] - s[i]);
      end
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic clear_queues();
    mon_val.delete(); mon_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  // Drive one contiguous in_en burst, then one low cycle; the model splits the
  // burst into MAX_LEN chunks and predicts each result and the edge it appears on.
  task automatic drive_stream(input mq_t modes, input uq_t data);
    uq_t cur;
    logic [1:0] fm;
    bit open;
    open = 1'b0;
    fm = 2'd0;
    for (int i = 0; i < data.size(); i++) begin
      @(negedge clk);
      bus.in_en = 1'b1;
      bus.mode = modes[i];
      bus.in_data = DATA_W'(data[i]);
      if (!open) begin open = 1'b1; fm = modes[i]; end
      cur.push_back(data[i]);
      if (cur.size() == MAX_LEN) begin
        exp_val.push_back(ref_result(fm, cur));
        exp_cyc.push_back(cyc + 1);
        cur.delete();
        open = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    bus.mode = 2'($urandom_range(0, 3));
    bus.in_data = DATA_W'($urandom_range(0, 255));
    if (cur.size() > 0) begin
      exp_val.push_back(ref_result(fm, cur));
      exp_cyc.push_back(cyc + 1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_en = 1'b0; bus.mode = 2'd0; bus.in_data = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %0b want 0", bus.out_en); end
    checks++;
    if (bus.out_data !== 17'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sum();
    uq_t d, want; mq_t m;
    clear_queues();
    d = '{32'd1, 32'd2, 32'd3, 32'd4}; m = '{2'd0, 2'd0, 2'd0, 2'd0}; want = '{32'd10};
    drive_stream(m, d);
    checks++;
    if (mon_val.size() !== want.size()) begin errors++; $display("FAIL sum_count got %0d want %0d", mon_val.size(), want.size()); end
    for (int i = 0; i < mon_val.size() && i < want.size(); i++) begin
      checks++; if (mon_val[i] !== want[i]) begin errors++; $display("FAIL sum_value got %0d want %0d", mon_val[i], want[i]); end
      checks++; if (mon_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL sum_timing got %0d want %0d", mon_cyc[i], exp_cyc[i]); end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.out_data !== 17'd10 || bus.out_en !== 1'b0) begin
      errors++; $display("FAIL sum_hold got data %0d en %0b want 10 en 0", bus.out_data, bus.out_en);
    end
  endtask

  task automatic test_max_min();
    uq_t d, want; mq_t m;
    clear_queues();
    d = '{32'd5, 32'd200, 32'd17};
    m = '{2'd1, 2'd1, 2'd1}; drive_stream(m, d);
    m = '{2'd2, 2'd2, 2'd2}; drive_stream(m, d);
    want = '{32'd200, 32'd5};
    checks++;
    if (mon_val.size() !== want.size()) begin errors++; $display("FAIL maxmin_count got %0d want %0d", mon_val.size(), want.size()); end
    for (int i = 0; i < mon_val.size() && i < want.size(); i++) begin
      checks++; if (mon_val[i] !== want[i]) begin errors++; $display("FAIL maxmin_value[%0d] got %0d want %0d", i, mon_val[i], want[i]); end
      checks++; if (mon_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL maxmin_timing[%0d] got %0d want %0d", i, mon_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_sad();
    uq_t d, want; mq_t m;
    clear_queues();
    d = '{32'd10, 32'd30, 32'd20}; m = '{2'd3, 2'd3, 2'd3}; drive_stream(m, d);
    d = '{32'd99}; m = '{2'd3}; drive_stream(m, d);
    want = '{32'd30, 32'd0};
    checks++;
    if (mon_val.size() !== want.size()) begin errors++; $display("FAIL sad_count got %0d want %0d", mon_val.size(), want.size()); end
    for (int i = 0; i < mon_val.size() && i < want.size(); i++) begin
      checks++; if (mon_val[i] !== want[i]) begin errors++; $display("FAIL sad_value[%0d] got %0d want %0d", i, mon_val[i], want[i]); end
      checks++; if (mon_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL sad_timing[%0d] got %0d want %0d", i, mon_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_forced_close();
    uq_t d, want; mq_t m;
    clear_queues();
    for (int i = 0; i < MAX_LEN; i++) begin d.push_back(32'd255); m.push_back(2'd0); end
    d.push_back(32'd7); m.push_back(2'd0);
    drive_stream(m, d);
    want = '{32'd130560, 32'd7};
    checks++;
    if (mon_val.size() !== want.size()) begin errors++; $display("FAIL forced_count got %0d want %0d", mon_val.size(), want.size()); end
    for (int i = 0; i < mon_val.size() && i < want.size(); i++) begin
      checks++; if (mon_val[i] !== want[i]) begin errors++; $display("FAIL forced_value[%0d] got %0d want %0d", i, mon_val[i], want[i]); end
      checks++; if (mon_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL forced_timing[%0d] got %0d want %0d", i, mon_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_mode_change();
    uq_t d, want; mq_t m;
    clear_queues();
    d = '{32'd1, 32'd1, 32'd1}; m = '{2'd0, 2'd1, 2'd1}; want = '{32'd3};
    drive_stream(m, d);
    checks++;
    if (mon_val.size() !== want.size()) begin errors++; $display("FAIL modechg_count got %0d want %0d", mon_val.size(), want.size()); end
    for (int i = 0; i < mon_val.size() && i < want.size(); i++) begin
      checks++; if (mon_val[i] !== want[i]) begin errors++; $display("FAIL modechg_value got %0d want %0d", mon_val[i], want[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    uq_t d, want; mq_t m;
    clear_queues();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.in_en = 1'b1; bus.mode = 2'd0; bus.in_data = 8'd9;
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_en !== 1'b0 || bus.out_data !== 17'd0) begin
      errors++; $display("FAIL midreset_clear got en %0b data %0d want en 0 data 0", bus.out_en, bus.out_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (mon_val.size() !== 0) begin errors++; $display("FAIL midreset_no_result got %0d pulses want 0", mon_val.size()); end
    clear_queues();
    d = '{32'd4, 32'd4}; m = '{2'd0, 2'd0}; want = '{32'd8};
    drive_stream(m, d);
    checks++;
    if (mon_val.size() !== want.size()) begin errors++; $display("FAIL midreset_count got %0d want %0d", mon_val.size(), want.size()); end
    for (int i = 0; i < mon_val.size() && i < want.size(); i++) begin
      checks++; if (mon_val[i] !== want[i]) begin errors++; $display("FAIL midreset_value got %0d want %0d", mon_val[i], want[i]); end
      checks++; if (mon_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL midreset_timing got %0d want %0d", mon_cyc[i], exp_cyc[i]); end
    end
  endtask

  task automatic test_random();
    uq_t d; mq_t m;
    int unsigned len;
    clear_queues();
    for (int f = 0; f < 24; f++) begin
      len = (f == 0) ? 32'd600 : $urandom_range(1, 20);
      d.delete(); m.delete();
      for (int i = 0; i < int'(len); i++) begin
        d.push_back($urandom_range(0, 255));
        m.push_back(2'($urandom_range(0, 3)));
      end
      drive_stream(m, d);
    end
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL random_count got %0d want %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++; if (mon_val[i] !== exp_val[i]) begin errors++; $display("FAIL random_value[%0d] got %0d want %0d", i, mon_val[i], exp_val[i]); end
      checks++; if (mon_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL random_timing[%0d] got %0d want %0d", i, mon_cyc[i], exp_cyc[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_max_min();
    test_sad();
    test_forced_close();
    test_mode_change();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnc_stream_engine.md
Name: cnc_stream_engine

Overview:
Responder end of the CNC interface: the compute engine that consumes the driver-side stream (in_en/mode/in_data) and returns results on out_en/out_data. Each contiguous run of in_en-high cycles is one frame. The engine reduces the frame according to the mode latched at its first sample and emits one 17-bit result per frame. The engine sits behind the CNC interface and is the DUT observed by the monitor.

Parameters:
DATA_W, 8, input sample width (unsigned)
OUT_W, 17, result width; must satisfy OUT_W >= DATA_W + clog2(MAX_LEN)
MAX_LEN, 512, maximum samples per frame; the frame is force-closed on reaching it

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
in_en  input  1  sample valid; contiguous high cycles form one frame
mode  input  2  operation select, sampled only on the first sample of a frame
in_data  input  DATA_W  unsigned sample
out_en  output  1  one-cycle result strobe
out_data  output  OUT_W  frame result, valid when out_en=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; acc, prev, count, mode_q cleared; out_en=0; out_data=0. Any partial frame is discarded and no out_en is produced for it.
- Inputs are sampled on posedge clk. The driver updates them on negedge.
- Modes:
  - 0: SUM, the unsigned sum of all samples.
  - 1: MAX, the largest sample.
  - 2: MIN, the smallest sample.
  - 3: SAD, the sum of |x[i]-x[i-1]| over consecutive samples.
- Width rules: all arithmetic is unsigned and zero-extended to OUT_W. With the defaults, SUM max is 512*255=130560 and SAD max is 511*255=130305, so neither can overflow and there is no saturation.
- FSM states: IDLE, ACC.
- IDLE, in_en=1 (first sample):
  - Latch mode_q=mode; set prev=in_data; set count=1.
  - Set acc = in_data for SUM/MAX/MIN, or 0 for SAD. Go to ACC.
- IDLE, in_en=0: hold; out_en=0.
- ACC, in_en=1:
  - acc updated per mode_q (add, max, min, or add |in_data-prev|); prev=in_data; count+1.
  - If the new count==MAX_LEN (forced close): out_data=updated acc, out_en=1 next cycle, go to IDLE.
- ACC, in_en=0 (normal close): out_data=acc, out_en=1 next cycle, go to IDLE.
- Latency: out_en is high for exactly one cycle, on the clock after the first posedge at which in_en is sampled low (normal close) or the MAX_LEN-th sample is taken (forced close).
- out_data holds its last value until the next result. out_en is 0 in every other cycle.
- Back-to-back frames:
  - After a forced close, in_en high on the next edge starts a new frame from IDLE. The out_en cycle of the previous frame can coincide with the first sample of the next frame.
  - Normal frames are separated by at least one in_en-low cycle by definition.
- mode changes during a frame are ignored; only mode_q is used.
- Single-sample frame: SUM/MAX/MIN return the sample; SAD returns 0.
- Ties in MAX/MIN have no effect on the result value.
- No backpressure: the consumer must accept out_en whenever asserted.

Test Plan:
- Reset, then mode=0, samples 1,2,3,4 then in_en=0 -> single out_en pulse one cycle later, out_data=10.
- mode=1, samples 5,200,17 -> out_data=200. Repeat with mode=2 -> out_data=5.
- mode=3, samples 10,30,20 -> out_data=30. mode=3 single sample 99 -> out_data=0.
- mode=0, 512 consecutive samples of 255 with in_en held high through sample 513 (value 7), then low:
  - out_data=130560 pulsed after the 512th sample edge.
  - A second frame containing 7 follows, giving out_data=7.
- mode=0 frame 1,1,1 with mode driven to 1 after the first sample -> out_data=3 (mode change ignored).
- Reset asserted after 3 samples of a frame -> out_en/out_data go to 0 immediately, no result for that frame. A subsequent frame of 4,4 -> out_data=8.
